// File: rtl/bb_ext_arbiter.sv
// Round-robin arbiter sharing the blackbone external bus among NUM_MASTERS requesters.
//
// One access per cycle, fully pipelined. A granted access with m_lock_i set starts a
// locked sequence in which only the owner may be granted. The sequence ends when the
// owner drops its lock, or it is forced to end after MAX_LOCK locked cycles.
// Read data is steered back to the issuing master by a two-stage tag pipeline.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_req_i           per-master access request
//   m_lock_i          per-master lock request, sampled with the granted access
//   m_addr_i          per-master address, master m at [m*ADDR_WIDTH +: ADDR_WIDTH]
//   m_we_i            per-master write enable (1 = write)
//   m_din_i           per-master write data, master m at [m*DATA_WIDTH +: DATA_WIDTH]
//   m_gnt_o           one-hot combinational grant
//   m_rvalid_o        read data valid, one-hot to the issuing master
//   m_rdata_o         shared read data (bus read data passed through)
//   lock_timeout_o    one-cycle pulse on a forced lock release
//   bb_ext_addr_o     registered bus address
//   bb_ext_din_o      registered bus write data
//   bb_ext_en_o       registered bus enable
//   bb_ext_we_o       registered bus write enable
//   bb_ext_dout_i     bus read data, valid one cycle after a read enable
module bb_ext_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS-1:0]            m_lock_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_din_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic                              lock_timeout_o,
    output logic [ADDR_WIDTH-1:0]             bb_ext_addr_o,
    output logic [DATA_WIDTH-1:0]             bb_ext_din_o,
    output logic                              bb_ext_en_o,
    output logic                              bb_ext_we_o,
    input  logic [DATA_WIDTH-1:0]             bb_ext_dout_i
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               win_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               gnt_any;
    logic               sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  en_q;
    logic                  we_q;

    // Read tag pipeline: stage 1 lines up with the bus issue, stage 2 with the read data.
    logic               tag1_vld_q, tag2_vld_q;
    logic [IDX_W-1:0]   tag1_idx_q, tag2_idx_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_MASTERS - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            cand_idx = IDX_W'((int'(ptr_q) + i) % int'(NUM_MASTERS));
            if (!win_found && m_req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_idx  = (state_q == StLocked) ? owner_q : win_idx;
        gnt_any  = (state_q == StLocked) ? m_req_i[owner_q] : win_found;
        sel_we   = m_we_i[sel_idx];
        sel_addr = m_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = m_din_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        m_gnt_o  = '0;
        if (gnt_any && !rst) begin
            m_gnt_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StArb: begin
                if (gnt_any) begin
                    if (m_lock_i[win_idx]) begin
                        // Pointer stays put; it advances past the owner on release.
                        state_d = StLocked;
                        owner_d = win_idx;
                        cnt_d   = '0;
                    end else begin
                        ptr_d = next_idx(win_idx);
                    end
                end
            end
            StLocked: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Lock low ends the sequence whether or not the owner is requesting; a
                // voluntary release takes precedence over the timeout.
                if (!m_lock_i[owner_q]) begin
                    state_d = StArb;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                    state_d   = StArb;
                    ptr_d     = next_idx(owner_q);
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StArb;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            din_q      <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            tag1_vld_q <= 1'b0;
            tag1_idx_q <= '0;
            tag2_vld_q <= 1'b0;
            tag2_idx_q <= '0;
        end else begin
            en_q <= gnt_any;
            if (gnt_any) begin
                addr_q <= sel_addr;
                din_q  <= sel_din;
                we_q   <= sel_we;
            end
            tag1_vld_q <= gnt_any && !sel_we;
            tag1_idx_q <= sel_idx;
            tag2_vld_q <= tag1_vld_q;
            tag2_idx_q <= tag1_idx_q;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        if (tag2_vld_q) begin
            m_rvalid_o[tag2_idx_q] = 1'b1;
        end
    end

    assign m_rdata_o      = bb_ext_dout_i;
    assign lock_timeout_o = timeout_q;
    assign bb_ext_addr_o  = addr_q;
    assign bb_ext_din_o   = din_q;
    assign bb_ext_en_o    = en_q;
    assign bb_ext_we_o    = we_q;

endmodule
